// File: rtl/limn2600_pkg.sv
// Shared definitions for the limn2600 cache line-fill engine.
// Holds the fill FSM state encoding and the default line geometry.
package limn2600_pkg;

  localparam int LINE_WORDS_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/limn2600_cache_fill.sv
// Critical-word-first cache line fill engine: fetches one line word by word
// from memory, writes each good beat into the cache, aborts on bus error or timeout.
module limn2600_cache_fill
  import limn2600_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_req_valid,
  output logic        fill_req_ready,
  input  logic [31:0] fill_req_addr,
  output logic        fill_done,
  output logic        fill_err,
  output logic        busy,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        cache_we,
  output logic [31:0] cache_addr_in,
  output logic [31:0] cache_data_in
);

  localparam int WIDX = $clog2(LINE_WORDS);
  localparam int OFF  = WIDX + 2;
  localparam int TW   = $clog2(TIMEOUT + 1);

  fill_state_e        state_q, state_d;
  logic [31-OFF:0]    line_q, line_d;
  logic [WIDX-1:0]    start_q, start_d;
  logic [WIDX-1:0]    beat_q, beat_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               we_q, we_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [WIDX-1:0]    widx;
  logic [31:0]        beat_addr;
  logic               last_beat;
  logic               tmo_hit;
  logic               addr_lsb_unused;

  // Word index wraps naturally in WIDX bits, so a fill never leaves its line.
  assign widx      = start_q + beat_q;
  assign beat_addr = {line_q, widx, 2'b00};
  assign last_beat = (beat_q == WIDX'(LINE_WORDS - 1));
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT));
  assign addr_lsb_unused = ^fill_req_addr[1:0];

  assign fill_req_ready = !rst && (state_q == ST_IDLE);
  assign busy           = !rst && (state_q != ST_IDLE);
  assign mem_req_valid  = !rst && (state_q == ST_ISSUE);
  assign mem_addr       = mem_req_valid ? beat_addr : '0;
  assign cache_we       = !rst && we_q;
  assign cache_addr_in  = rst ? '0 : waddr_q;
  assign cache_data_in  = rst ? '0 : wdata_q;
  assign fill_done      = !rst && done_q;
  assign fill_err       = !rst && err_q;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    start_d = start_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fill_req_valid && fill_req_ready) begin
          line_d  = fill_req_addr[31:OFF];
          start_d = fill_req_addr[OFF-1:2];
          beat_d  = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (mem_req_ready) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            we_d    = 1'b1;
            waddr_d = beat_addr;
            wdata_d = mem_rsp_data;
            if (last_beat) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              beat_d  = beat_q + WIDX'(1);
              state_d = ST_ISSUE;
            end
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      start_q <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      start_q <= start_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_limn2600_cache_fill.sv
// Directed bench for limn2600_cache_fill with a scoreboard of expected memory
// reads and cache writes, plus a small latency-configurable memory model.
module tb_limn2600_cache_fill;

  localparam int LW  = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        fill_req_valid;
  logic        fill_req_ready;
  logic [31:0] fill_req_addr;
  logic        fill_done;
  logic        fill_err;
  logic        busy;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        cache_we;
  logic [31:0] cache_addr_in;
  logic [31:0] cache_data_in;

  always #5 clk = ~clk;

  limn2600_cache_fill #(.LINE_WORDS(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
    .fill_req_addr(fill_req_addr), .fill_done(fill_done), .fill_err(fill_err),
    .busy(busy), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err), .cache_we(cache_we), .cache_addr_in(cache_addr_in),
    .cache_data_in(cache_data_in)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic [31:0] exp_mem_q[$];
  logic [63:0] exp_wr_q[$];

  logic [31:0] data_xor = '0;
  int  mem_lat = 1;
  int  err_beat = 0;
  bit  no_rsp = 1'b0;
  bit  pend = 1'b0;
  int  pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int  rsp_num = 0;
  int  rsp_edge = -1;
  int  err_edge = -1;
  int  hs_cycle = -1;
  int  done_cnt = 0, err_cnt = 0, we_cnt = 0;
  int  err_cycle = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (32'h0000_00A0 + {28'h0, a[5:2]}) ^ data_xor;
  endfunction

  // Expected read order is critical word first, wrapping inside the line.
  task automatic expect_fill(input logic [31:0] addr, input int n_req, input int n_wr);
    logic [31:0] base;
    logic [31:0] a;
    int start;
    base  = addr & ~32'(LW * 4 - 1);
    start = int'((addr >> 2) & 32'(LW - 1));
    for (int k = 0; k < n_req; k++) begin
      a = base + 32'(4 * ((start + k) % LW));
      exp_mem_q.push_back(a);
      if (k < n_wr) exp_wr_q.push_back({a, mem_word(a)});
    end
  endtask

  task automatic tick();
    logic hs;
    logic [31:0] hs_addr;
    logic [63:0] w;
    @(negedge clk);
    hs      = mem_req_valid & mem_req_ready;
    hs_addr = mem_addr;
    @(posedge clk);
    #1;
    cycle++;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rsp_data  = '0;
    if (hs) begin
      hs_cycle = cycle;
      if (exp_mem_q.size() == 0) check("mem_unexp_req", 32'(exp_mem_q.size()), 32'd1);
      else check("mem_addr_order", hs_addr, exp_mem_q.pop_front());
      if (!no_rsp) begin
        pend = 1'b1;
        pend_cnt = mem_lat;
        pend_addr = hs_addr;
      end
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend = 1'b0;
        rsp_num++;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(pend_addr);
        if (rsp_num == err_beat) begin
          mem_rsp_err = 1'b1;
          err_edge = cycle + 1;
        end else begin
          rsp_edge = cycle + 1;
        end
      end
    end
    if (cache_we) begin
      we_cnt++;
      check("we_timing", 32'(cycle), 32'(rsp_edge));
      if (exp_wr_q.size() == 0) check("cache_unexp_we", 32'(exp_wr_q.size()), 32'd1);
      else begin
        w = exp_wr_q.pop_front();
        check("cache_addr", cache_addr_in, w[63:32]);
        check("cache_data", cache_data_in, w[31:0]);
      end
      if (!fill_done) check("issue_after_beat", 32'(mem_req_valid), 32'd1);
    end
    if (fill_done) begin
      done_cnt++;
      check("done_with_we", 32'(cache_we), 32'd1);
      check("done_err_excl", 32'(fill_err), 32'd0);
    end
    if (fill_err) begin
      err_cnt++;
      err_cycle = cycle;
      check("err_no_we", 32'(cache_we), 32'd0);
      check("busy_at_err", 32'(busy), 32'd0);
    end
  endtask

  task automatic reset_counts();
    done_cnt = 0;
    err_cnt  = 0;
    we_cnt   = 0;
    rsp_num  = 0;
    err_cycle = -1;
  endtask

  task automatic start_fill(input logic [31:0] addr);
    check("req_ready_idle", 32'(fill_req_ready), 32'd1);
    fill_req_valid = 1'b1;
    fill_req_addr  = addr;
    tick();
    fill_req_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic check_good_fill(input string tag);
    tick();
    check({tag, "_done"}, 32'(done_cnt), 32'd1);
    check({tag, "_err"}, 32'(err_cnt), 32'd0);
    check({tag, "_writes"}, 32'(we_cnt), 32'(LW));
    check({tag, "_wr_left"}, 32'(exp_wr_q.size()), 32'd0);
    check({tag, "_rd_left"}, 32'(exp_mem_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    fill_req_valid = 1'b0;
    fill_req_addr = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    mem_rsp_err = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 32'(fill_req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_memv", 32'(mem_req_valid), 32'd0);
    check("rst_we", 32'(cache_we), 32'd0);
    check("rst_done", 32'(fill_done), 32'd0);
    check("rst_err", 32'(fill_err), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(fill_req_ready), 32'd1);

    // Stray response while idle must be ignored
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    check("idle_ignore_we", 32'(cache_we), 32'd0);
    check("idle_ignore_busy", 32'(busy), 32'd0);

    // Aligned fill, 1-cycle latency
    reset_counts();
    mem_lat = 1;
    data_xor = '0;
    expect_fill(32'h0000_1000, LW, LW);
    start_fill(32'h0000_1000);
    wait_end(60);
    check_good_fill("aligned");

    // Wrapping fill, 3-cycle latency
    reset_counts();
    mem_lat = 3;
    data_xor = 32'h5500_0000;
    expect_fill(32'h0000_2008, LW, LW);
    start_fill(32'h0000_2008);
    wait_end(80);
    check_good_fill("wrap");

    // Backpressure on the request channel
    reset_counts();
    mem_lat = 2;
    mem_req_ready = 1'b0;
    expect_fill(32'h0000_3004, LW, LW);
    start_fill(32'h0000_3004);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(mem_req_valid), 32'd1);
      check("bp_addr", mem_addr, 32'h0000_3004);
      check("bp_we", 32'(cache_we), 32'd0);
    end
    mem_req_ready = 1'b1;
    wait_end(80);
    check_good_fill("bp");

    // Bus error on the second beat
    reset_counts();
    mem_lat = 1;
    err_beat = 2;
    expect_fill(32'h0000_4000, 2, 1);
    start_fill(32'h0000_4000);
    wait_end(40);
    check("berr_err", 32'(err_cnt), 32'd1);
    check("berr_done", 32'(done_cnt), 32'd0);
    check("berr_timing", 32'(err_cycle), 32'(err_edge));
    tick();
    check("berr_writes", 32'(we_cnt), 32'd1);
    check("berr_busy", 32'(busy), 32'd0);
    check("berr_rd_left", 32'(exp_mem_q.size()), 32'd0);
    check("berr_wr_left", 32'(exp_wr_q.size()), 32'd0);
    err_beat = 0;

    // Timeout with no response at all
    reset_counts();
    no_rsp = 1'b1;
    expect_fill(32'h0000_5010, 1, 0);
    start_fill(32'h0000_5010);
    wait_end(40);
    check("tmo_err", 32'(err_cnt), 32'd1);
    check("tmo_delay", 32'(err_cycle - hs_cycle), 32'd9);
    check("tmo_writes", 32'(we_cnt), 32'd0);
    check("tmo_done", 32'(done_cnt), 32'd0);
    tick();
    check("tmo_busy", 32'(busy), 32'd0);
    no_rsp = 1'b0;

    // Reset while waiting on the first beat; response lands afterwards
    reset_counts();
    mem_lat = 6;
    expect_fill(32'h0000_6000, 1, 0);
    start_fill(32'h0000_6000);
    tick();
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(fill_req_ready), 32'd0);
    check("mid_rst_memv", 32'(mem_req_valid), 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    check("mid_writes", 32'(we_cnt), 32'd0);
    check("mid_done", 32'(done_cnt), 32'd0);
    check("mid_err", 32'(err_cnt), 32'd0);
    check("mid_ready", 32'(fill_req_ready), 32'd1);
    check("mid_rd_left", 32'(exp_mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
